// File: rtl/ascon_permutation.sv
// Ascon 320-bit permutation p^a with a configurable number of rounds per clock.
// Jobs are taken through a valid/ready handshake and sequenced by an IDLE/RUN/DONE FSM.
module ascon_permutation #(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [319:0] state_in,
    input  logic [3:0]   rounds_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [319:0] state_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
    localparam logic [3:0] STEP  = 4'(UNROLL);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [319:0] x_q, x_d;
    logic [3:0]   rem_q, rem_d;
    logic [3:0]   idx_q, idx_d;

    logic [319:0] stage;
    logic [3:0]   step;
    logic [3:0]   eff_rounds;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [7:0]  rc;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        rc = 8'hF0 - 8'h0F * {4'h0, idx};
        x2[7:0] = x2[7:0] ^ rc;
        // Bit-sliced 5-bit S-box: each bit position j is one S-box column.
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fsm_d = fsm_q;
        x_d   = x_q;
        rem_d = rem_q;
        idx_d = idx_q;

        // Stages past the remaining count pass the state through untouched.
        stage = x_q;
        for (int k = 0; k < UNROLL; k++) begin
            if (4'(k) < rem_q) stage = ascon_round(stage, idx_q + 4'(k));
        end
        step       = (rem_q < STEP) ? rem_q : STEP;
        eff_rounds = (rounds_in == 4'd0 || rounds_in > MAX_R) ? MAX_R : rounds_in;

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    x_d   = state_in;
                    rem_d = eff_rounds;
                    idx_d = MAX_R - eff_rounds;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                x_d   = stage;
                rem_d = rem_q - step;
                idx_d = idx_q + step;
                if (rem_q == step) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
            x_q   <= '0;
            rem_q <= '0;
            idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            x_q   <= x_d;
            rem_q <= rem_d;
            idx_q <= idx_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);
    assign state_out = x_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Bench for ascon_permutation: three instances (UNROLL 1, 4, 3) checked against a
// table-driven software model of Ascon p^a through an expected-result queue.
module tb_ascon_permutation;

    localparam int ND = 3;
    localparam int UN [ND] = '{1, 4, 3};

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [7:0] RC [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    localparam logic [319:0] PAT = 320'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_deadbeefcafef00d;

    logic         clk = 1'b0;
    logic         rst;
    logic [319:0] s_in  [ND];
    logic [3:0]   r_in  [ND];
    logic         iv    [ND];
    logic         ir    [ND];
    logic [319:0] s_out [ND];
    logic         ov    [ND];
    logic         ordy  [ND];
    logic         bz    [ND];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    typedef struct {
        logic [319:0] st;
        int           lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    ascon_permutation #(.UNROLL(1)) u_dut0 (
        .clk(clk), .rst(rst), .state_in(s_in[0]), .rounds_in(r_in[0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .state_out(s_out[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0]));
    ascon_permutation #(.UNROLL(4)) u_dut1 (
        .clk(clk), .rst(rst), .state_in(s_in[1]), .rounds_in(r_in[1]), .in_valid(iv[1]),
        .in_ready(ir[1]), .state_out(s_out[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1]));
    ascon_permutation #(.UNROLL(3)) u_dut2 (
        .clk(clk), .rst(rst), .state_in(s_in[2]), .rounds_in(r_in[2]), .in_valid(iv[2]),
        .in_ready(ir[2]), .state_out(s_out[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2]));

    function automatic logic [63:0] ror_m(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic int eff_rounds(input logic [3:0] r);
        return (r == 4'd0 || r > 4'd12) ? 12 : int'(r);
    endfunction

    function automatic int lat_of(input int d, input int a);
        return (a + UN[d] - 1) / UN[d];
    endfunction

    // Reference permutation: S-box by table lookup on each 5-bit column.
    function automatic logic [319:0] model_perm(input logic [319:0] st, input int a);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, o;
        for (int w = 0; w < 5; w++) x[w] = st[319 - 64*w -: 64];
        for (int r = 12 - a; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ RC[r];
            for (int j = 0; j < 64; j++) begin
                col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o   = SBOX[col];
                for (int w = 0; w < 5; w++) y[w][j] = o[4 - w];
            end
            x[0] = y[0] ^ ror_m(y[0], 19) ^ ror_m(y[0], 28);
            x[1] = y[1] ^ ror_m(y[1], 61) ^ ror_m(y[1], 39);
            x[2] = y[2] ^ ror_m(y[2], 1)  ^ ror_m(y[2], 6);
            x[3] = y[3] ^ ror_m(y[3], 10) ^ ror_m(y[3], 17);
            x[4] = y[4] ^ ror_m(y[4], 7)  ^ ror_m(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom)};
        return v;
    endfunction

    task automatic push_job(input int d, input logic [319:0] st, input logic [3:0] r);
        exp_t e;
        e.st  = model_perm(st, eff_rounds(r));
        e.lat = lat_of(d, eff_rounds(r));
        sb.push_back(e);
    endtask

    // Runs one job on DUT d from IDLE (called at a negedge) and checks it fully.
    task automatic run_job(input int d, input logic [319:0] st, input logic [3:0] r,
                           input string name, output logic [319:0] got);
        int   cyc;
        exp_t e;
        n_checks++;
        if (ir[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%b required 1", name, ir[d]);
        end
        push_job(d, st, r);
        s_in[d] = st; r_in[d] = r; iv[d] = 1'b1; ordy[d] = 1'b0;
        @(negedge clk);
        iv[d] = 1'b0;
        n_checks++;
        if (bz[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy: busy=%b required 1", name, bz[d]);
        end
        cyc = 0;
        while (ov[d] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, e.lat);
        end
        n_checks++;
        if (s_out[d] !== e.st) begin
            n_fail++;
            $display("FAIL %s_state: got %h required %h", name, s_out[d], e.st);
        end
        got = s_out[d];
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        n_checks++;
        if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_return_idle: in_ready=%b out_valid=%b required 1/0", name, ir[d], ov[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            s_in[d] = PAT; r_in[d] = 4'd12; iv[d] = 1'b1; ordy[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || s_out[d] !== '0) begin
                n_fail++;
                $display("FAIL reset_dut%0d: ready=%b valid=%b busy=%b state=%h required 1/0/0/0",
                         d, ir[d], ov[d], bz[d], s_out[d]);
            end
            iv[d] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_p12_zero();
        logic [319:0] g;
        run_job(0, '0, 4'd12, "p12_zero", g);
    endtask

    task automatic test_unroll();
        logic [319:0] g1, g4, g;
        run_job(1, PAT, 4'd6, "u4_a6", g4);
        run_job(0, PAT, 4'd6, "u1_a6", g1);
        n_checks++;
        if (g4 !== g1) begin
            n_fail++;
            $display("FAIL u4_vs_u1: got %h required %h", g4, g1);
        end
        run_job(2, PAT, 4'd5, "u3_a5_mask", g);
        run_job(1, ~PAT, 4'd1, "u4_a1", g);
        run_job(2, ~PAT, 4'd12, "u3_a12", g);
        run_job(1, PAT, 4'd11, "u4_a11_mask", g);
    endtask

    task automatic test_round_alias();
        logic [319:0] g;
        logic [3:0]   rv [3];
        rv = '{4'd0, 4'd15, 4'd13};
        for (int i = 0; i < 3; i++) begin
            run_job(0, PAT, rv[i], $sformatf("alias_u1_r%0d", rv[i]), g);
            run_job(2, PAT, rv[i], $sformatf("alias_u3_r%0d", rv[i]), g);
        end
    endtask

    task automatic test_hold();
        int   cyc;
        exp_t e;
        logic [319:0] q;
        q = rnd320();
        push_job(1, q, 4'd12);
        s_in[1] = q; r_in[1] = 4'd12; iv[1] = 1'b1; ordy[1] = 1'b0;
        @(negedge clk);
        iv[1] = 1'b0;
        cyc = 0;
        while (ov[1] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d required %0d", cyc, e.lat);
        end
        for (int c = 0; c < 10; c++) begin
            s_in[1] = ~q; r_in[1] = 4'd3; iv[1] = 1'b1;
            @(negedge clk);
            n_checks++;
            if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || bz[1] !== 1'b0 || s_out[1] !== e.st) begin
                n_fail++;
                $display("FAIL hold_stable_c%0d: valid=%b ready=%b busy=%b state=%h required 1/0/0 %h",
                         c, ov[1], ir[1], bz[1], s_out[1], e.st);
            end
        end
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        iv[1]   = 1'b0;
        n_checks++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0 || bz[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: ready=%b valid=%b busy=%b required 1/0/0", ir[1], ov[1], bz[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [319:0] g;
        logic         saw;
        s_in[0] = PAT; r_in[0] = 4'd12; iv[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bz[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_run_busy: busy=%b required 1", bz[0]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || s_out[0] !== '0) begin
            n_fail++;
            $display("FAIL rst_run_outputs: ready=%b valid=%b busy=%b state=%h required 1/0/0/0",
                     ir[0], ov[0], bz[0], s_out[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ov[0] === 1'b1) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_run_no_valid: out_valid seen=%b required 0", saw);
        end
        ordy[0] = 1'b0;
        run_job(0, ~PAT, 4'd12, "rst_next_job", g);
    endtask

    task automatic test_back_to_back();
        localparam int NJ = 6;
        logic [3:0] rv [NJ];
        int acc  [NJ];
        int done [NJ];
        int jl   [NJ];
        rv = '{4'd12, 4'd5, 4'd1, 4'd8, 4'd0, 4'd4};
        ordy[1] = 1'b1;
        fork
            begin
                for (int k = 0; k < NJ; k++) begin
                    logic [319:0] st;
                    int t;
                    st = rnd320();
                    jl[k] = lat_of(1, eff_rounds(rv[k]));
                    push_job(1, st, rv[k]);
                    s_in[1] = st; r_in[1] = rv[k]; iv[1] = 1'b1;
                    t = 0;
                    while (ir[1] !== 1'b1 && t < 50) begin
                        @(negedge clk);
                        t++;
                    end
                    acc[k] = cycle + 1;
                    @(negedge clk);
                end
                iv[1] = 1'b0;
            end
            begin
                for (int k = 0; k < NJ; k++) begin
                    exp_t e;
                    int t;
                    t = 0;
                    while (ov[1] !== 1'b1 && t < 50) begin
                        @(negedge clk);
                        t++;
                    end
                    done[k] = cycle;
                    e = sb.pop_front();
                    n_checks++;
                    if (s_out[1] !== e.st) begin
                        n_fail++;
                        $display("FAIL b2b_state_j%0d: got %h required %h", k, s_out[1], e.st);
                    end
                    @(negedge clk);
                end
            end
        join
        ordy[1] = 1'b0;
        for (int k = 0; k < NJ; k++) begin
            n_checks++;
            if (done[k] - acc[k] !== jl[k]) begin
                n_fail++;
                $display("FAIL b2b_latency_j%0d: got %0d required %0d", k, done[k] - acc[k], jl[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (acc[k] - acc[k-1] !== jl[k-1] + 2) begin
                    n_fail++;
                    $display("FAIL b2b_period_j%0d: got %0d required %0d", k, acc[k] - acc[k-1], jl[k-1] + 2);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_p12_zero();
        test_unroll();
        test_round_alias();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
